// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and defaults for the fetch/data memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2,
        DRAIN  = 2'd3
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_port_arbiter_ack_timer.sv
// rtl/mem_port_arbiter_ack_timer.sv - counts unacknowledged busy cycles and flags the timeout
module ack_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // expired marks the TIMEOUT-th enabled cycle, so the arbiter leaves on that edge
    assign expired = enable && (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch and data requests onto one shared memory port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stallF,
    output logic              stallM,
    output logic              err
);

    arb_state_t state, state_d;

    logic              expired;
    logic              load_d, load_i;
    logic              done_d, done_i;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;

    ack_timer #(.TIMEOUT(TIMEOUT)) u_ack_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_d == IDLE),
        .enable  ((state != IDLE) && !mem_ack),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        load_d  = 1'b0;
        load_i  = 1'b0;
        done_d  = 1'b0;
        done_i  = 1'b0;
        case (state)
            IDLE: begin
                if (d_req) begin
                    load_d  = 1'b1;
                    state_d = BUSY_D;
                end else if (if_req && !flush) begin
                    load_i  = 1'b1;
                    state_d = BUSY_I;
                end
            end
            BUSY_D: begin
                if (mem_ack || expired) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            BUSY_I: begin
                // a flush in the same cycle as completion or timeout discards the fetch
                if (mem_ack || expired) begin
                    done_i  = !flush;
                    state_d = IDLE;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ack || expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            err      <= 1'b0;
        end else begin
            if_valid <= done_i;
            d_valid  <= done_d;
            if (load_d) begin
                addr_q  <= d_addr;
                we_q    <= d_we;
                wdata_q <= d_wdata;
            end else if (load_i) begin
                addr_q  <= if_addr;
                we_q    <= 1'b0;
            end
            // expired only fires without mem_ack, so a timed-out owner reads zero
            if (done_d) begin
                d_rdata <= expired ? '0 : mem_rdata;
            end
            if (done_i) begin
                if_rdata <= expired ? '0 : mem_rdata;
            end
            if (expired) begin
                err <= 1'b1;
            end
        end
    end

    assign mem_req   = (state != IDLE);
    assign mem_we    = (state == BUSY_D) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign stallF    = if_req & ~if_valid;
    assign stallM    = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stallF;
    logic        stallM;
    logic        err;

    int checks;
    int failures;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stallF    (stallF),
        .stallM    (stallM),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        flush     = 1'b0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        @(negedge clk);
        @(negedge clk);

        check("rst_mem_req",  mem_req,   0);
        check("rst_mem_we",   mem_we,    0);
        check("rst_mem_addr", mem_addr,  0);
        check("rst_if_valid", if_valid,  0);
        check("rst_d_valid",  d_valid,   0);
        check("rst_err",      err,       0);
        check("rst_if_rdata", if_rdata,  0);
        check("rst_d_rdata",  d_rdata,   0);
        rst = 1'b0;
        tick();

        // fetch 0x40, ack latency 3
        if_req  = 1'b1;
        if_addr = 32'h40;
        tick();
        check("f_mem_req",  mem_req,  1);
        check("f_mem_addr", mem_addr, 32'h40);
        check("f_mem_we",   mem_we,   0);
        check("f_stallF1",  stallF,   1);
        tick();
        check("f_stallF2",  stallF,   1);
        check("f_if_valid_early", if_valid, 0);
        tick();
        check("f_mem_req3", mem_req,  1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        check("f_if_valid", if_valid, 1);
        check("f_if_rdata", if_rdata, 32'h1234_5678);
        check("f_stallF_rel", stallF, 0);
        check("f_idle_req", mem_req,  0);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        tick();
        check("f_valid_once", if_valid, 0);

        // simultaneous store and fetch: data wins
        if_req  = 1'b1;
        if_addr = 32'h44;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h100;
        d_wdata = 32'hCAFE_F00D;
        tick();
        check("p_mem_addr_d",  mem_addr,  32'h100);
        check("p_mem_we_d",    mem_we,    1);
        check("p_mem_wdata",   mem_wdata, 32'hCAFE_F00D);
        check("p_stallF_a",    stallF,    1);
        check("p_stallM_a",    stallM,    1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0;
        tick();
        check("p_d_valid",     d_valid,   1);
        check("p_stallM_rel",  stallM,    0);
        check("p_stallF_b",    stallF,    1);
        check("p_idle_gap",    mem_req,   0);
        mem_ack = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        tick();
        check("p_mem_addr_i",  mem_addr,  32'h44);
        check("p_mem_we_i",    mem_we,    0);
        check("p_stallF_c",    stallF,    1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hAAAA_5555;
        tick();
        check("p_if_valid",    if_valid,  1);
        check("p_if_rdata",    if_rdata,  32'hAAAA_5555);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        tick();

        // flush one cycle after grant, ack after 4 cycles -> DRAIN
        if_req  = 1'b1;
        if_addr = 32'h80;
        tick();
        check("dr_granted", mem_req, 1);
        flush = 1'b1;
        tick();
        flush  = 1'b0;
        if_req = 1'b0;
        check("dr_hold_req", mem_req, 1);
        check("dr_we",       mem_we,  0);
        tick();
        check("dr_hold_req2", mem_req, 1);
        check("dr_no_valid1", if_valid, 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        check("dr_no_valid", if_valid, 0);
        check("dr_rdata_kept", if_rdata, 32'hAAAA_5555);
        check("dr_idle", mem_req, 0);
        mem_ack = 1'b0;
        tick();

        // flush coincident with ack in BUSY_I
        if_req  = 1'b1;
        if_addr = 32'h90;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        flush     = 1'b1;
        tick();
        check("fa_no_valid", if_valid, 0);
        check("fa_idle",     mem_req,  0);
        check("fa_rdata_kept", if_rdata, 32'hAAAA_5555);
        mem_ack = 1'b0;
        flush   = 1'b0;
        if_req  = 1'b0;
        tick();

        // flush during BUSY_D has no effect
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h200;
        tick();
        check("fd_we",   mem_we,   0);
        check("fd_addr", mem_addr, 32'h200);
        flush = 1'b1;
        tick();
        check("fd_still_busy", mem_req, 1);
        check("fd_stallM",     stallM,  1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h3333_4444;
        tick();
        check("fd_d_valid", d_valid, 1);
        check("fd_d_rdata", d_rdata, 32'h3333_4444);
        mem_ack = 1'b0;
        d_req   = 1'b0;
        flush   = 1'b0;
        tick();

        // timeout with TIMEOUT=8 and no ack
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h300;
        d_wdata = 32'h55;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("to_err_low", err,     0);
            check("to_busy",    mem_req, 1);
            tick();
        end
        check("to_err_set",  err,     1);
        check("to_d_valid",  d_valid, 1);
        check("to_d_rdata",  d_rdata, 0);
        check("to_idle",     mem_req, 0);
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        check("to_err_sticky", err,     1);
        check("to_valid_once", d_valid, 0);
        tick();
        check("to_err_sticky2", err, 1);

        // reset mid BUSY_D, then a stray ack
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h400;
        d_wdata = 32'h77;
        tick();
        check("rs_busy", mem_req, 1);
        rst = 1'b1;
        #1;
        check("rs_mem_req",   mem_req,   0);
        check("rs_mem_we",    mem_we,    0);
        check("rs_mem_addr",  mem_addr,  0);
        check("rs_mem_wdata", mem_wdata, 0);
        check("rs_err",       err,       0);
        check("rs_if_rdata",  if_rdata,  0);
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h99;
        tick();
        check("st_d_valid",  d_valid,  0);
        check("st_if_valid", if_valid, 0);
        check("st_d_rdata",  d_rdata,  0);
        check("st_mem_req",  mem_req,  0);
        check("st_err",      err,      0);
        mem_ack = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum number of cycles to wait for mem_ack.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port if_req  in  1  fetch request, held until if_valid.
REQ-007 SHALL have port if_addr  in  ADDR_W  fetch address (the PC).
REQ-008 SHALL have port if_rdata  out  DATA_W  fetched instruction.
REQ-009 SHALL have port if_valid  out  1  one-cycle fetch-complete pulse.
REQ-010 SHALL have port d_req  in  1  data request, held until d_valid.
REQ-011 SHALL have port d_we  in  1  data write enable.
REQ-012 SHALL have port d_addr  in  ADDR_W  data address.
REQ-013 SHALL have port d_wdata  in  DATA_W  data write value.
REQ-014 SHALL have port d_rdata  out  DATA_W  data read value.
REQ-015 SHALL have port d_valid  out  1  one-cycle data-complete pulse.
REQ-016 SHALL have port flush  in  1  cancel the current or pending fetch (branch taken).
REQ-017 SHALL have port mem_req  out  1  shared memory port request.
REQ-018 SHALL have port mem_we  out  1  shared memory port write enable.
REQ-019 SHALL have port mem_addr  out  ADDR_W  shared memory port address.
REQ-020 SHALL have port mem_wdata  out  DATA_W  shared memory port write data.
REQ-021 SHALL have port mem_rdata  in  DATA_W  shared memory port read data.
REQ-022 SHALL have port mem_ack  in  1  shared memory port completion, 1 cycle, latency 1..N.
REQ-023 SHALL have port stallF  out  1  stall to the fetch latch.
REQ-024 SHALL have port stallM  out  1  stall to the memory-stage latch.
REQ-025 SHALL have port err  out  1  sticky timeout flag.

Function
REQ-026 SHALL implement the states IDLE, BUSY_D, BUSY_I and DRAIN.
REQ-027 In IDLE with d_req=1, SHALL at the clock edge latch d_addr, d_we and d_wdata into registers and go to BUSY_D; data has fixed priority over fetch.
REQ-028 In IDLE with d_req=0, if_req=1 and flush=0, SHALL latch if_addr and go to BUSY_I.
REQ-029 SHALL drive mem_req=1 in BUSY_D, BUSY_I and DRAIN, and 0 in IDLE; mem_addr, mem_we and mem_wdata SHALL come from the registers and stay stable until mem_ack.
REQ-030 SHALL force mem_we=0 in BUSY_I and DRAIN.
REQ-031 On mem_ack in BUSY_D, SHALL capture mem_rdata into d_rdata, pulse d_valid for the next cycle, and go to IDLE.
REQ-032 On mem_ack in BUSY_I, SHALL capture mem_rdata into if_rdata, pulse if_valid for the next cycle, and go to IDLE.
REQ-033 With flush=1 in BUSY_I and no mem_ack, SHALL go to DRAIN; on mem_ack in DRAIN it SHALL go to IDLE with no if_valid and if_rdata unchanged.
REQ-034 flush=1 coincident with mem_ack in BUSY_I SHALL discard the fetch: no if_valid, go to IDLE.
REQ-035 flush SHALL have no effect in BUSY_D.
REQ-036 mem_ack in IDLE SHALL be ignored.
REQ-037 Minimum access latency: request seen in IDLE at edge n, mem_req high at n+1, valid pulse one cycle after the mem_ack edge; returning to IDLE between accesses is mandatory.
REQ-038 stallF SHALL equal if_req & ~if_valid, combinational.
REQ-039 stallM SHALL equal d_req & ~d_valid, combinational.
REQ-040 SHALL count cycles spent in a non-IDLE state without mem_ack, clearing the count on entry to IDLE.
REQ-041 When the count reaches TIMEOUT, SHALL set err, go to IDLE, and pulse the owning valid with rdata=0; the DRAIN owner gets no pulse.
REQ-042 err SHALL stay set until reset.

Reset
REQ-043 rst=1 SHALL immediately force IDLE, mem_req=0, mem_we=0, if_valid=0, d_valid=0, err=0, counter=0, and if_rdata=d_rdata=mem_addr=mem_wdata=0.
REQ-044 Reset mid-transaction SHALL abandon the access, and any later mem_ack SHALL be ignored per REQ-036.

Structure
REQ-045 The state encoding typedef and the default TIMEOUT SHALL live in the shared pipeline package.
REQ-046 The timeout counter SHALL be a sub-module, ack_timer, with inputs clk, rst, clear and enable and output expired.

Verification
REQ-047 Set if_req=1 with if_addr=0x40, memory ack latency 3 -> mem_addr=0x40, mem_we=0; if_valid pulses once with the memory word; stallF=1 until that pulse.
REQ-048 Raise if_req and d_req (store, 0x100, 0xCAFEF00D) in the same cycle -> the data access is granted first with mem_we=1; the fetch is granted next; stallF stays high throughout.
REQ-049 Pulse flush 1 cycle after a fetch is granted, ack after 4 cycles -> DRAIN is entered, mem_req is held until ack, there is no if_valid, and the state then returns to IDLE.
REQ-050 Send flush coincident with mem_ack in BUSY_I -> no if_valid; pulse flush during BUSY_D -> d_valid is delivered normally.
REQ-051 Set TIMEOUT=8 and never ack -> err=1 after 8 cycles, d_valid pulses with d_rdata=0, and err stays set.
REQ-052 Assert rst during BUSY_D, then send a stray mem_ack after release -> all outputs are 0, with no valid pulse.
